// File: rtl/hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hit_arbiter
// Purpose  : Contact resolver between the two player FSMs. Issues hit/block
//            pulses, keeps round score, sequences RUN/FREEZE/OVER.
// Revision : 1.0 - initial release
// ============================================================================
module hit_arbiter #(
    parameter logic [9:0] BASIC_REACH   = 10'd48,
    parameter logic [9:0] DIR_REACH     = 10'd64,
    parameter int         WIN_POINTS    = 3,
    parameter int         FREEZE_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       round_reset,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_x,
    input  logic [9:0] p2_x,
    output logic       p1_got_hit,
    output logic       p1_got_blocked,
    output logic       p2_got_hit,
    output logic       p2_got_blocked,
    output logic [1:0] p1_score,
    output logic [1:0] p2_score,
    output logic       trade,
    output logic       freeze,
    output logic       round_over,
    output logic [1:0] winner
);

    localparam int         c_CNT_W    = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [1:0] c_WIN      = 2'(WIN_POINTS);

    localparam logic [3:0] c_ST_BACK  = 4'd1;
    localparam logic [3:0] c_ST_BASIC = 4'd4;
    localparam logic [3:0] c_ST_DIR   = 4'd7;
    localparam logic [3:0] c_ST_HITST = 4'd9;
    localparam logic [3:0] c_ST_BLKST = 4'd10;

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_FREEZE   = 2'd1;
    localparam logic [1:0] c_OVER     = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]         r_p1_score, w_p1_score_nxt;
    logic [1:0]         r_p2_score, w_p2_score_nxt;
    logic               r_p1_latch, w_p1_latch_nxt;
    logic               r_p2_latch, w_p2_latch_nxt;
    logic               r_p1_got_hit, w_p1_got_hit_nxt;
    logic               r_p1_got_blocked, w_p1_got_blocked_nxt;
    logic               r_p2_got_hit, w_p2_got_hit_nxt;
    logic               r_p2_got_blocked, w_p2_got_blocked_nxt;
    logic               r_trade, w_trade_nxt;

    logic [9:0] w_gap;
    logic       w_p1_active, w_p2_active;
    logic       w_p1_cand, w_p2_cand;
    logic       w_p1_stunned, w_p2_stunned;
    logic       w_p1_hit, w_p1_block, w_p2_hit, w_p2_block;

    // P1 faces right and P2 faces left, so only p2_x >= p1_x gives a real gap
    assign w_gap = (p2_x >= p1_x) ? (p2_x - p1_x) : 10'd0;

    assign w_p1_active = (p1_state == c_ST_BASIC) || (p1_state == c_ST_DIR);
    assign w_p2_active = (p2_state == c_ST_BASIC) || (p2_state == c_ST_DIR);

    assign w_p1_cand = !r_p1_latch &&
                       (((p1_state == c_ST_BASIC) && (w_gap <= BASIC_REACH)) ||
                        ((p1_state == c_ST_DIR)   && (w_gap <= DIR_REACH)));
    assign w_p2_cand = !r_p2_latch &&
                       (((p2_state == c_ST_BASIC) && (w_gap <= BASIC_REACH)) ||
                        ((p2_state == c_ST_DIR)   && (w_gap <= DIR_REACH)));

    assign w_p1_stunned = (p1_state == c_ST_HITST) || (p1_state == c_ST_BLKST);
    assign w_p2_stunned = (p2_state == c_ST_HITST) || (p2_state == c_ST_BLKST);

    // wN_hit / wN_block: player N's attack lands on / is blocked by the opponent
    assign w_p1_hit   = w_p1_cand && !w_p2_stunned && (p2_state != c_ST_BACK);
    assign w_p1_block = w_p1_cand && !w_p2_stunned && (p2_state == c_ST_BACK);
    assign w_p2_hit   = w_p2_cand && !w_p1_stunned && (p1_state != c_ST_BACK);
    assign w_p2_block = w_p2_cand && !w_p1_stunned && (p1_state == c_ST_BACK);

    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_p1_score_nxt       = r_p1_score;
        w_p2_score_nxt       = r_p2_score;
        w_p1_latch_nxt       = r_p1_latch && w_p1_active;
        w_p2_latch_nxt       = r_p2_latch && w_p2_active;
        w_p1_got_hit_nxt     = 1'b0;
        w_p1_got_blocked_nxt = 1'b0;
        w_p2_got_hit_nxt     = 1'b0;
        w_p2_got_blocked_nxt = 1'b0;
        w_trade_nxt          = 1'b0;

        case (r_state)
            c_RUN: begin
                if (w_p1_hit && w_p2_hit) begin
                    w_p1_got_hit_nxt = 1'b1;
                    w_p2_got_hit_nxt = 1'b1;
                    w_trade_nxt      = 1'b1;
                    w_p1_latch_nxt   = 1'b1;
                    w_p2_latch_nxt   = 1'b1;
                end else begin
                    if (w_p1_hit || w_p1_block) begin
                        w_p1_latch_nxt       = 1'b1;
                        w_p2_got_hit_nxt     = w_p1_hit;
                        w_p2_got_blocked_nxt = w_p1_block;
                        if (w_p1_hit && (r_p1_score != c_WIN))
                            w_p1_score_nxt = r_p1_score + 2'd1;
                    end
                    if (w_p2_hit || w_p2_block) begin
                        w_p2_latch_nxt       = 1'b1;
                        w_p1_got_hit_nxt     = w_p2_hit;
                        w_p1_got_blocked_nxt = w_p2_block;
                        if (w_p2_hit && (r_p2_score != c_WIN))
                            w_p2_score_nxt = r_p2_score + 2'd1;
                    end
                end
                if (w_p1_hit || w_p2_hit) begin
                    w_state_nxt = c_FREEZE;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            c_FREEZE: begin
                if (r_cnt == '0) begin
                    if ((r_p1_score == c_WIN) || (r_p2_score == c_WIN))
                        w_state_nxt = c_OVER;
                    else
                        w_state_nxt = c_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_OVER: begin
                w_state_nxt = c_OVER;
            end
            default: begin
                w_state_nxt = c_RUN;
            end
        endcase

        if (round_reset) begin
            w_state_nxt          = c_RUN;
            w_cnt_nxt            = '0;
            w_p1_score_nxt       = 2'd0;
            w_p2_score_nxt       = 2'd0;
            w_p1_latch_nxt       = 1'b0;
            w_p2_latch_nxt       = 1'b0;
            w_p1_got_hit_nxt     = 1'b0;
            w_p1_got_blocked_nxt = 1'b0;
            w_p2_got_hit_nxt     = 1'b0;
            w_p2_got_blocked_nxt = 1'b0;
            w_trade_nxt          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= c_RUN;
            r_cnt            <= '0;
            r_p1_score       <= 2'd0;
            r_p2_score       <= 2'd0;
            r_p1_latch       <= 1'b0;
            r_p2_latch       <= 1'b0;
            r_p1_got_hit     <= 1'b0;
            r_p1_got_blocked <= 1'b0;
            r_p2_got_hit     <= 1'b0;
            r_p2_got_blocked <= 1'b0;
            r_trade          <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_p1_score       <= w_p1_score_nxt;
            r_p2_score       <= w_p2_score_nxt;
            r_p1_latch       <= w_p1_latch_nxt;
            r_p2_latch       <= w_p2_latch_nxt;
            r_p1_got_hit     <= w_p1_got_hit_nxt;
            r_p1_got_blocked <= w_p1_got_blocked_nxt;
            r_p2_got_hit     <= w_p2_got_hit_nxt;
            r_p2_got_blocked <= w_p2_got_blocked_nxt;
            r_trade          <= w_trade_nxt;
        end
    end

    assign p1_got_hit     = r_p1_got_hit;
    assign p1_got_blocked = r_p1_got_blocked;
    assign p2_got_hit     = r_p2_got_hit;
    assign p2_got_blocked = r_p2_got_blocked;
    assign p1_score       = r_p1_score;
    assign p2_score       = r_p2_score;
    assign trade          = r_trade;
    assign freeze         = (r_state == c_FREEZE);
    assign round_over     = (r_state == c_OVER);
    assign winner         = !round_over            ? 2'd0 :
                            (r_p1_score == c_WIN)  ? 2'd1 :
                            (r_p2_score == c_WIN)  ? 2'd2 : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_arbiter
// Purpose  : Directed self-checking bench for hit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_arbiter;

    logic       clk;
    logic       reset_n;
    logic       round_reset;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_x, p2_x;
    logic       p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked;
    logic [1:0] p1_score, p2_score;
    logic       trade, freeze, round_over;
    logic [1:0] winner;

    int tests_run    = 0;
    int tests_failed = 0;

    hit_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .round_reset    (round_reset),
        .p1_state       (p1_state),
        .p2_state       (p2_state),
        .p1_x           (p1_x),
        .p2_x           (p2_x),
        .p1_got_hit     (p1_got_hit),
        .p1_got_blocked (p1_got_blocked),
        .p2_got_hit     (p2_got_hit),
        .p2_got_blocked (p2_got_blocked),
        .p1_score       (p1_score),
        .p2_score       (p2_score),
        .trade          (trade),
        .freeze         (freeze),
        .round_over     (round_over),
        .winner         (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one frame; inputs set after this are sampled on the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_round_reset();
        p1_state    = 4'd0;
        p2_state    = 4'd0;
        round_reset = 1'b1;
        tick();
        round_reset = 1'b0;
    endtask

    // Runs until freeze drops; returns frames seen high after the call and any pulses
    task automatic run_out_freeze(output int frames, output int pulses, output bit timeout);
        frames  = 0;
        pulses  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            pulses += int'(p1_got_hit) + int'(p2_got_hit) + int'(p1_got_blocked) + int'(p2_got_blocked);
            if (!freeze) begin
                timeout = 1'b0;
                break;
            end
            frames++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; round_reset = 1'b0;
        p1_state = 4'd0; p2_state = 4'd0; p1_x = 10'd100; p2_x = 10'd140;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        tests_run++;
        if ({p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked, trade, freeze, round_over} !== 7'b0
            || p1_score !== 2'd0 || p2_score !== 2'd0 || winner !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: pulses/flags=%b scores=%0d/%0d winner=%0d, required all zero",
                     {p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked, trade, freeze, round_over},
                     p1_score, p2_score, winner);
        end
    endtask

    task automatic test_basic_hit();
        int frames, pulses; bit to;
        p1_x = 10'd100; p2_x = 10'd140; p1_state = 4'd3; p2_state = 4'd0;
        tick();
        tests_run++;
        if (p2_got_hit !== 1'b0) begin
            tests_failed++; $display("FAIL hit_early: p2_got_hit=%b, required 0", p2_got_hit);
        end
        p1_state = 4'd4;
        tick();
        tests_run++;
        if (p2_got_hit !== 1'b1 || p1_score !== 2'd1 || freeze !== 1'b1) begin
            tests_failed++;
            $display("FAIL hit_pulse: p2_got_hit=%b p1_score=%0d freeze=%b, required 1/1/1",
                     p2_got_hit, p1_score, freeze);
        end
        tick();
        p1_state = 4'd3;
        tests_run++;
        if (p2_got_hit !== 1'b0) begin
            tests_failed++; $display("FAIL hit_one_cycle: p2_got_hit=%b, required 0", p2_got_hit);
        end
        run_out_freeze(frames, pulses, to);
        tests_run++;
        if (to || frames + 2 !== 30 || pulses !== 0) begin
            tests_failed++;
            $display("FAIL freeze_len: frames=%0d pulses=%0d timeout=%b, required 30/0/0",
                     frames + 2, pulses, to);
        end
        tests_run++;
        if (round_over !== 1'b0 || p1_score !== 2'd1) begin
            tests_failed++;
            $display("FAIL back_to_run: round_over=%b p1_score=%0d, required 0/1", round_over, p1_score);
        end
    endtask

    task automatic test_block_reach();
        int blk, hits, fr;
        // dir attack at gap 60 into a backing P1: one block, no freeze
        p1_x = 10'd100; p2_x = 10'd160; p1_state = 4'd1; p2_state = 4'd7;
        blk = 0; hits = 0; fr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            blk += int'(p1_got_blocked); hits += int'(p1_got_hit); fr += int'(freeze);
        end
        p2_state = 4'd0;
        tick();
        tests_run++;
        if (blk !== 1 || hits !== 0 || fr !== 0 || p1_score !== 2'd1 || p2_score !== 2'd0) begin
            tests_failed++;
            $display("FAIL block_dir60: blocks=%0d hits=%0d freeze=%0d scores=%0d/%0d, required 1/0/0/1/0",
                     blk, hits, fr, p1_score, p2_score);
        end
        p2_state = 4'd4; blk = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); blk += int'(p1_got_blocked) + int'(p1_got_hit);
        end
        p2_state = 4'd0; tick();
        tests_run++;
        if (blk !== 0) begin
            tests_failed++; $display("FAIL basic_out_of_reach60: pulses=%0d, required 0", blk);
        end
        p2_x = 10'd148; p2_state = 4'd4; blk = 0;
        for (int i = 0; i < 2; i++) begin
            tick(); blk += int'(p1_got_blocked);
        end
        p2_state = 4'd0; tick();
        tests_run++;
        if (blk !== 1) begin
            tests_failed++; $display("FAIL basic_reach48: blocks=%0d, required 1", blk);
        end
        p2_x = 10'd149; p2_state = 4'd4; blk = 0;
        for (int i = 0; i < 2; i++) begin
            tick(); blk += int'(p1_got_blocked);
        end
        p2_state = 4'd0; tick();
        tests_run++;
        if (blk !== 0) begin
            tests_failed++; $display("FAIL basic_reach49: blocks=%0d, required 0", blk);
        end
    endtask

    task automatic test_single_connect();
        int hits, frames, pulses; bit to;
        do_round_reset();
        p1_x = 10'd100; p2_x = 10'd140; p2_state = 4'd0; p1_state = 4'd7; hits = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); hits += int'(p2_got_hit);
        end
        p1_state = 4'd3;
        run_out_freeze(frames, pulses, to);
        tests_run++;
        if (hits + pulses !== 1 || p1_score !== 2'd1 || to) begin
            tests_failed++;
            $display("FAIL single_connect: hits=%0d score=%0d timeout=%b, required 1/1/0",
                     hits + pulses, p1_score, to);
        end
        p2_state = 4'd9; p1_state = 4'd4; hits = 0;
        for (int i = 0; i < 2; i++) begin
            tick(); hits += int'(p2_got_hit) + int'(p2_got_blocked);
        end
        tests_run++;
        if (hits !== 0 || p1_score !== 2'd1 || freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL stun_invuln: pulses=%0d score=%0d freeze=%b, required 0/1/0", hits, p1_score, freeze);
        end
        p2_state = 4'd0;
        tick();
        tests_run++;
        if (p2_got_hit !== 1'b1 || p1_score !== 2'd2) begin
            tests_failed++;
            $display("FAIL after_stun_connect: p2_got_hit=%b score=%0d, required 1/2", p2_got_hit, p1_score);
        end
        p1_state = 4'd0;
        run_out_freeze(frames, pulses, to);
    endtask

    task automatic test_trade();
        int frames, pulses; bit to;
        do_round_reset();
        p1_x = 10'd100; p2_x = 10'd140; p1_state = 4'd4; p2_state = 4'd4;
        tick();
        tests_run++;
        if ({p1_got_hit, p2_got_hit, trade, freeze} !== 4'b1111 || p1_score !== 2'd0 || p2_score !== 2'd0) begin
            tests_failed++;
            $display("FAIL trade: hit1/hit2/trade/freeze=%b scores=%0d/%0d, required 1111 0/0",
                     {p1_got_hit, p2_got_hit, trade, freeze}, p1_score, p2_score);
        end
        p1_state = 4'd0; p2_state = 4'd0;
        run_out_freeze(frames, pulses, to);
        tests_run++;
        if (to || round_over !== 1'b0 || trade !== 1'b0) begin
            tests_failed++;
            $display("FAIL trade_freeze_exit: timeout=%b round_over=%b, required 0/0", to, round_over);
        end
    endtask

    task automatic test_round_end();
        int frames, pulses, hits; bit to;
        do_round_reset();
        p1_x = 10'd100; p2_x = 10'd140; p2_state = 4'd0; hits = 0;
        for (int k = 1; k <= 3; k++) begin
            p1_state = 4'd4;
            tick();
            hits += int'(p2_got_hit);
            p1_state = 4'd3;
            run_out_freeze(frames, pulses, to);
        end
        tests_run++;
        if (hits !== 3 || round_over !== 1'b1 || winner !== 2'd1 || p1_score !== 2'd3) begin
            tests_failed++;
            $display("FAIL round_over: hits=%0d round_over=%b winner=%0d score=%0d, required 3/1/1/3",
                     hits, round_over, winner, p1_score);
        end
        hits = 0; p1_state = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick(); hits += int'(p2_got_hit) + int'(p1_got_hit);
        end
        tests_run++;
        if (hits !== 0 || p1_score !== 2'd3 || round_over !== 1'b1) begin
            tests_failed++;
            $display("FAIL over_no_pulse: pulses=%0d score=%0d, required 0/3", hits, p1_score);
        end
        do_round_reset();
        tests_run++;
        if (p1_score !== 2'd0 || p2_score !== 2'd0 || round_over !== 1'b0 || winner !== 2'd0 || freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL round_reset: scores=%0d/%0d round_over=%b winner=%0d, required 0/0/0/0",
                     p1_score, p2_score, round_over, winner);
        end
    endtask

    task automatic test_async_reset();
        p1_x = 10'd100; p2_x = 10'd140; p2_state = 4'd0; p1_state = 4'd4;
        tick();
        p1_state = 4'd3;
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (freeze !== 1'b0 || p1_score !== 2'd0 || p2_got_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: freeze=%b score=%0d p2_got_hit=%b, required 0/0/0",
                     freeze, p1_score, p2_got_hit);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        p1_state = 4'd4;
        tick();
        tests_run++;
        if (p2_got_hit !== 1'b1 || p1_score !== 2'd1 || freeze !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_after_reset: p2_got_hit=%b score=%0d freeze=%b, required 1/1/1",
                     p2_got_hit, p1_score, freeze);
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_block_reach();
        test_single_connect();
        test_trade();
        test_round_end();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hit_arbiter.md
Name: hit_arbiter

Overview:
- Shared contact resolver between the two player sprite FSMs.
- Each cycle (one game frame) it compares both players' FSM states and x positions, and detects when an active attack reaches the opponent.
- It decides hit vs block and issues one-cycle got_hit / got_blocked pulses back to each FSM.
- It keeps per-round score and sequences the round through freeze and game-over phases.

Parameters:
- BASIC_REACH, 10'd48: max pixel gap at which a basic attack (state 4) connects.
- DIR_REACH, 10'd64: max pixel gap at which a directional attack (state 7) connects.
- WIN_POINTS, 3: hits needed to win the round.
- FREEZE_FRAMES, 30: cycles of freeze after each scored hit or trade.

Ports:
- clk  in  1  frame clock; the FSMs step on the same edge.
- reset_n  in  1  asynchronous, active-low reset.
- round_reset  in  1  synchronous pulse; clears scores and returns to RUN.
- p1_state  in  4  P1 FSM state code (0 IDLE … 10 Blockstun).
- p2_state  in  4  P2 FSM state code.
- p1_x  in  10  P1 x position. P1 always faces right.
- p2_x  in  10  P2 x position. P2 always faces left.
- p1_got_hit, p1_got_blocked  out  1 each  registered pulses to P1 FSM.
- p2_got_hit, p2_got_blocked  out  1 each  registered pulses to P2 FSM.
- p1_score, p2_score  out  2 each  points this round.
- trade  out  1  registered pulse; simultaneous mutual hit.
- freeze  out  1  high during FREEZE; top level gates FSM inputs with it.
- round_over  out  1  high in OVER.
- winner  out  2  0 none, 1 P1, 2 P2; valid while round_over.

Behaviour:
- Reset (reset_n low, async) values:
  - All pulse outputs, trade, freeze and round_over are 0.
  - Scores are 0 and winner is 0.
  - Connect latches are cleared and the state machine is RUN.
- Gap: gap = p2_x − p1_x when p2_x ≥ p1_x, else 0. Computed at 10 bits with no wrap.
- Attack reach:
  - Attacker in state 4: reach = BASIC_REACH.
  - Attacker in state 7: reach = DIR_REACH.
  - Any other state: no attack.
- Candidate: attacker in an active state, gap ≤ reach, and the attacker's connect latch is clear.
- Connect latch:
  - Set on the cycle an event is issued for that attacker.
  - Cleared on the first cycle the attacker's state is neither 4 nor 7.
  - This limits each attack to one event.
- Defender response:
  - Defender in Hitstun (9) or Blockstun (10): candidate discarded, latch not set.
  - Defender in Backward (1): block. Defender's got_blocked pulses, no score change.
  - Any other defender state, including attack states: hit. Defender's got_hit pulses and attacker's score increments.
- Latency: events are resolved from the cycle-N inputs; pulses are high for exactly cycle N+1.
- Simultaneous candidates, both resolving as hit:
  - Both got_hit pulses and trade pulse together.
  - Scores unchanged; both latches set.
  - Go to FREEZE.
- Simultaneous candidates, hit and block: each is resolved independently; no trade.
- State machine:
  - RUN:
    - Events resolve normally.
    - A scored hit or trade loads freeze_cnt = FREEZE_FRAMES − 1 and goes to FREEZE.
    - A block stays in RUN.
  - FREEZE:
    - freeze = 1; all candidates are suppressed (no pulses, latches untouched). freeze_cnt decrements each cycle.
    - At 0, if either score equals WIN_POINTS, go to OVER; else go to RUN.
  - OVER:
    - round_over = 1; winner is set from the score that reached WIN_POINTS.
    - No pulses. Held until round_reset.
- round_reset:
  - Has priority in every state.
  - Next cycle: scores 0, latches cleared, winner 0, state RUN, pending pulses dropped.
- Scores saturate at WIN_POINTS and never wrap.
- reset_n asserted mid-freeze or mid-pulse: all outputs go to reset values immediately, with no completion of the pending pulse.
- Undefined state codes (11–15) are treated as non-attacking, non-stunned defenders, i.e. hittable.

Test Plan:
1. Basic hit:
   - Stimulus: p1_x=100, p2_x=140, p1_state 3→4 for 2 cycles, p2_state=0.
   - Response: p2_got_hit high for exactly 1 cycle, one cycle after the first state-4 cycle. p1_score=1. freeze high for 30 cycles, then RUN.
2. Block and reach:
   - Stimulus A: gap=60, p2 state 7, p1_state=1.
   - Response A: p1_got_blocked pulse once; scores unchanged; no freeze.
   - Stimulus B: same with p2 state 4.
   - Response B: no pulse (60 > 48).
3. Single connect and stun invulnerability:
   - Stimulus A: state 7 held for 3 cycles within reach.
   - Response A: exactly one pulse.
   - Stimulus B: defender in state 9.
   - Response B: no pulse, and a later in-reach active attack still connects.
4. Trade:
   - Stimulus: both players in state 4, gap=40, neither blocking.
   - Response: p1_got_hit, p2_got_hit and trade all pulse on the same cycle; scores unchanged; FREEZE entered.
5. Round end:
   - Stimulus: three P1 hits separated by freezes.
   - Response: after the third freeze expires, round_over=1 and winner=1. Further in-reach attacks produce no pulses. round_reset pulse clears scores and returns to RUN next cycle.
6. Async reset:
   - Stimulus: drop reset_n mid-FREEZE, between clock edges.
   - Response: freeze, scores and pulses go to 0 immediately; after release, state is RUN.
